// File: rtl/seg7_readback.sv
// Receive-side monitor for a two-digit 7-segment bus: synchronizes, debounces,
// decodes to BCD and checks that accepted values count 00..99 with wrap.
module seg7_readback #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       C,
  input  logic       CLR,
  input  logic [7:0] seg_in1,
  input  logic [7:0] seg_in2,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic       valid,
  output logic       invalid,
  output logic       seq_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [3:0] STAB_LAST = 4'(STABLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_sync1;
  logic [15:0] r_sync_word;
  logic [15:0] r_last_word;
  logic [3:0]  r_stab_cnt;
  logic [3:0]  w_stab_nxt;
  logic        w_load;
  logic        w_changed;
  logic        r_have_prev;
  logic [3:0]  r_digit1;
  logic [3:0]  r_digit2;
  logic        r_valid;
  logic        r_invalid;
  logic        r_seq_err;
  logic [7:0]  r_err_count;
  logic [4:0]  w_dec1;
  logic [4:0]  w_dec2;
  logic        w_ok;
  logic        w_same;
  logic [3:0]  w_succ1;
  logic [3:0]  w_succ2;
  logic        w_seq_bad;

  // Returns {legal, bcd}; the decimal point is ignored.
  function automatic logic [4:0] seg_decode(input logic [7:0] seg);
    case (seg[6:0])
      7'h3F:   seg_decode = {1'b1, 4'd0};
      7'h06:   seg_decode = {1'b1, 4'd1};
      7'h5B:   seg_decode = {1'b1, 4'd2};
      7'h4F:   seg_decode = {1'b1, 4'd3};
      7'h66:   seg_decode = {1'b1, 4'd4};
      7'h6D:   seg_decode = {1'b1, 4'd5};
      7'h7D:   seg_decode = {1'b1, 4'd6};
      7'h07:   seg_decode = {1'b1, 4'd7};
      7'h7F:   seg_decode = {1'b1, 4'd8};
      7'h6F:   seg_decode = {1'b1, 4'd9};
      default: seg_decode = {1'b0, 4'd0};
    endcase
  endfunction

  // Two-stage synchronizer for both buses as one word
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_sync1     <= 16'h0000;
      r_sync_word <= 16'h0000;
    end else begin
      r_sync1     <= {seg_in2, seg_in1};
      r_sync_word <= r_sync1;
    end
  end

  assign w_changed = (r_sync_word != r_last_word);

  // Filter FSM next state; CAPTURE is entered on the edge the count reaches STABLE_CYCLES
  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab_cnt;
    w_load      = 1'b0;
    case (r_state)
      SETTLE: begin
        if (w_changed) begin
          w_load     = 1'b1;
          w_stab_nxt = 4'd0;
        end else begin
          w_stab_nxt = r_stab_cnt + 4'd1;
          if (r_stab_cnt == STAB_LAST) begin
            w_state_nxt = CAPTURE;
          end else begin
            w_state_nxt = SETTLE;
          end
        end
      end
      CAPTURE: w_state_nxt = HOLD;
      HOLD: begin
        if (w_changed) begin
          w_load      = 1'b1;
          w_stab_nxt  = 4'd0;
          w_state_nxt = SETTLE;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = SETTLE;
        w_stab_nxt  = 4'd0;
      end
    endcase
  end

  // Filter state, settle counter and pattern under observation
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_state     <= SETTLE;
      r_stab_cnt  <= 4'd0;
      r_last_word <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
      if (w_load) begin
        r_last_word <= r_sync_word;
      end
    end
  end

  assign w_dec1 = seg_decode(r_last_word[7:0]);
  assign w_dec2 = seg_decode(r_last_word[15:8]);
  assign w_ok   = w_dec1[4] & w_dec2[4];
  assign w_same = r_have_prev && (w_dec1[3:0] == r_digit1) && (w_dec2[3:0] == r_digit2);

  // Successor of the last accepted value, modulo 100
  always_comb begin
    w_succ1 = r_digit1 + 4'd1;
    w_succ2 = r_digit2;
    if (r_digit1 == 4'd9) begin
      w_succ1 = 4'd0;
      if (r_digit2 == 4'd9) begin
        w_succ2 = 4'd0;
      end else begin
        w_succ2 = r_digit2 + 4'd1;
      end
    end else begin
      w_succ1 = r_digit1 + 4'd1;
    end
  end

  assign w_seq_bad = r_have_prev && ((w_dec1[3:0] != w_succ1) || (w_dec2[3:0] != w_succ2));

  // Capture actions: invalid beats duplicate-drop beats accept
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_digit1    <= 4'd0;
      r_digit2    <= 4'd0;
      r_valid     <= 1'b0;
      r_invalid   <= 1'b0;
      r_seq_err   <= 1'b0;
      r_err_count <= 8'd0;
      r_have_prev <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_invalid <= 1'b0;
      r_seq_err <= 1'b0;
      if (r_state == CAPTURE) begin
        if (!w_ok) begin
          r_invalid <= 1'b1;
          if (r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
          end
        end else if (!w_same) begin
          r_digit1    <= w_dec1[3:0];
          r_digit2    <= w_dec2[3:0];
          r_valid     <= 1'b1;
          r_have_prev <= 1'b1;
          if (w_seq_bad) begin
            r_seq_err <= 1'b1;
            if (r_err_count != 8'hFF) begin
              r_err_count <= r_err_count + 8'd1;
            end
          end
        end
      end
    end
  end

  assign digit1    = r_digit1;
  assign digit2    = r_digit2;
  assign valid     = r_valid;
  assign invalid   = r_invalid;
  assign seq_err   = r_seq_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_seg7_readback.sv
// Scoreboard bench for seg7_readback: a reference model predicts each capture
// (kind, digits, error count, edge) and a negedge monitor compares DUT pulses.
module tb_seg7_readback;

  localparam int STABLE = 4;
  localparam logic [7:0] SEG [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                      8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  typedef struct {
    logic [2:0] p;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [7:0] e;
    int         cyc;
  } exp_t;

  logic       C = 1'b0;
  logic       CLR = 1'b1;
  logic [7:0] seg_in1 = 8'h00;
  logic [7:0] seg_in2 = 8'h00;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic       valid;
  logic       invalid;
  logic       seq_err;
  logic [7:0] err_count;

  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  exp_t  q[$];

  logic [16:0] m_word = 17'h0;
  logic        m_have = 1'b0;
  int          m_val = 0;
  int          m_err = 0;

  seg7_readback #(.STABLE_CYCLES(STABLE)) dut (
    .C(C), .CLR(CLR), .seg_in1(seg_in1), .seg_in2(seg_in2),
    .digit1(digit1), .digit2(digit2), .valid(valid), .invalid(invalid),
    .seq_err(seq_err), .err_count(err_count)
  );

  always #5 C = ~C;
  always @(posedge C) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int dec(input logic [7:0] s);
    logic [7:0] t;
    for (int i = 0; i < 10; i++) begin
      t = SEG[i];
      if (t[6:0] == s[6:0]) return i;
    end
    return -1;
  endfunction

  task automatic model_event(input logic [7:0] s2, input logic [7:0] s1, input int ecyc);
    int   d1, d2, v;
    logic sq;
    exp_t e;
    d1 = dec(s1);
    d2 = dec(s2);
    e.cyc = ecyc;
    if (d1 < 0 || d2 < 0) begin
      if (m_err < 255) m_err++;
      e.p = 3'b010; e.d2 = 4'(m_val / 10); e.d1 = 4'(m_val % 10); e.e = 8'(m_err);
      q.push_back(e);
    end else begin
      v = d2 * 10 + d1;
      if (!(m_have && v == m_val)) begin
        sq = m_have && (v != (m_val + 1) % 100);
        if (sq && m_err < 255) m_err++;
        m_val = v;
        m_have = 1'b1;
        e.p = sq ? 3'b101 : 3'b100; e.d2 = 4'(d2); e.d1 = 4'(d1); e.e = 8'(m_err);
        q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    check("drain", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  // Drive a new bus word at a negedge; it is first sampled at the next posedge
  task automatic apply(input logic [7:0] s2, input logic [7:0] s1, input int hold);
    @(negedge C);
    seg_in2 = s2;
    seg_in1 = s1;
    if ({1'b0, s2, s1} != m_word) model_event(s2, s1, cyc + 1 + STABLE + 3);
    m_word = {1'b0, s2, s1};
    repeat (hold) @(negedge C);
    #1;
    drain();
  endtask

  task automatic release_clr(input logic [7:0] s2, input logic [7:0] s1);
    @(negedge C);
    seg_in2 = s2;
    seg_in1 = s1;
    CLR = 1'b0;
    m_word = 17'h0; m_have = 1'b0; m_val = 0; m_err = 0;
    if ({1'b0, s2, s1} != m_word) model_event(s2, s1, cyc + 1 + STABLE + 3);
    m_word = {1'b0, s2, s1};
    repeat (20) @(negedge C);
    #1;
    drain();
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_digit1"}, 32'(digit1), 32'd0);
    check({pfx, "_digit2"}, 32'(digit2), 32'd0);
    check({pfx, "_valid"}, 32'(valid), 32'd0);
    check({pfx, "_invalid"}, 32'(invalid), 32'd0);
    check({pfx, "_seq_err"}, 32'(seq_err), 32'd0);
    check({pfx, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  // Scoreboard monitor: every pulse must match the oldest prediction
  always @(negedge C) begin
    exp_t e;
    if (valid || invalid || seq_err) begin
      if (q.size() == 0) begin
        check("spurious", 32'({valid, invalid, seq_err}), 32'd0);
      end else begin
        e = q.pop_front();
        check("pulse", 32'({valid, invalid, seq_err}), 32'(e.p));
        check("digits", 32'({digit2, digit1}), 32'({e.d2, e.d1}));
        check("errc", 32'(err_count), 32'(e.e));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    logic [7:0] a, b;
    int w;
    repeat (5) @(negedge C);
    #1;
    check_zero("reset");
    release_clr(8'h3F, 8'h06);

    // count 02..99 then wrap to 00; DP set on the ones digit of 99
    for (int v = 2; v <= 100; v++) begin
      w = v % 100;
      a = SEG[w / 10];
      b = SEG[w % 10] | ((w == 99) ? 8'h80 : 8'h00);
      apply(a, b, 20);
    end

    @(negedge C);
    CLR = 1'b1;
    repeat (3) @(negedge C);
    release_clr(8'h66, 8'h06);
    apply(8'h66, 8'h4F, 20);
    apply(8'h66, 8'h66, 20);
    apply(8'h06, 8'h00, 20);
    apply(8'h66, 8'h66, 20);

    for (int i = 0; i < 13; i++) begin
      @(negedge C);
      seg_in2 = 8'h66;
      seg_in1 = (i % 2 == 0) ? 8'h06 : 8'h5B;
      repeat (2) @(negedge C);
    end
    m_word = 17'h1_0000;
    apply(8'h66, 8'h5B, 20);

    for (int i = 0; i < 300; i++) begin
      apply(8'h06, (i % 2 == 1) ? 8'h01 : 8'h00, 10);
    end
    check("saturated", 32'(err_count), 32'd255);

    @(negedge C);
    seg_in2 = 8'h66;
    seg_in1 = 8'h4F;
    repeat (2) @(negedge C);
    CLR = 1'b1;
    #1;
    check_zero("clr_abort");
    repeat (10) @(negedge C);
    #1;
    drain();
    release_clr(8'h66, 8'h4F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
